// File: rtl/program_loader.sv
// Loads instruction memory from a framed byte stream (count, big-endian words, XOR checksum)
// and holds the processor core in reset until a load completes with a good checksum.
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              load_mem_en,
    output logic [ADDR_W-1:0] load_mem_addr,
    output logic [31:0]       load_mem_data,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_COLLECT,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       word;
    logic [7:0]        csum;
    logic              take;
    logic              hdr_bad;

    logic in_ready_next;
    logic load_mem_en_next;
    logic core_rst_n_next;
    logic busy_next;
    logic done_next;
    logic err_next;

    assign take    = in_valid && in_ready;
    assign hdr_bad = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_B);

    // Status outputs are decoded from the next state and registered, so they
    // always line up with the state register without extra latency.
    // NOTE: sequential blocks use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            load_mem_en <= 1'b0;
            core_rst_n  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready    <= in_ready_next;
            load_mem_en <= load_mem_en_next;
            core_rst_n  <= core_rst_n_next;
            busy        <= busy_next;
            done        <= done_next;
            err         <= err_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_HDR;
            S_HDR:     if (take) state_next = hdr_bad ? S_ERR : S_COLLECT;
            S_COLLECT: if (take && byte_idx == 2'd3) state_next = S_WRITE;
            S_WRITE:   state_next = (word_idx == last_idx) ? S_CSUM : S_COLLECT;
            S_CSUM:    if (take) state_next = (in_data == csum) ? S_DONE : S_ERR;
            S_DONE:    if (start) state_next = S_HDR;
            S_ERR:     if (start) state_next = S_HDR;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_next    = 1'b0;
        load_mem_en_next = 1'b0;
        core_rst_n_next  = 1'b0;
        busy_next        = 1'b0;
        done_next        = 1'b0;
        err_next         = 1'b0;
        case (state_next)
            S_HDR, S_COLLECT, S_CSUM: begin
                in_ready_next = 1'b1;
                busy_next     = 1'b1;
            end
            S_WRITE: begin
                load_mem_en_next = 1'b1;
                busy_next        = 1'b1;
            end
            S_DONE: begin
                done_next       = 1'b1;
                core_rst_n_next = 1'b1;
            end
            S_ERR:   err_next = 1'b1;
            default: ;
        endcase
    end

    // Datapath: word assembly, running checksum, indices and the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx      <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            word          <= '0;
            csum          <= '0;
            load_mem_addr <= '0;
            load_mem_data <= '0;
        end else begin
            case (state)
                S_HDR: begin
                    if (take) begin
                        last_idx <= ADDR_W'(in_data - 8'd1);
                        csum     <= in_data;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                S_COLLECT: begin
                    if (take) begin
                        word     <= {word[23:0], in_data};
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            load_mem_addr <= word_idx;
                            load_mem_data <= {word[23:0], in_data};
                        end
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    byte_idx <= '0;
                end
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        csum     <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
